cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/rr_picker.sv | 40 ++++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: functional-unit count, result and tag widths,
// the "no producer" tag and the common data bus record.
//   NUM_UNITS : number of functional units that produce results
//   DATA_W    : result width
//   TAG_W     : producer tag width (tag = unit index + 1, 0 = none)
//   TAG_NONE  : tag value meaning "no producer"
//   cdb_t     : one common-data-bus beat {valid, tag, data}
package cpu_pkg;

    localparam int NUM_UNITS = 7;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 3;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker (purely combinational).
// The search starts at the entry after ptr and wraps modulo N, so the
// most recently served entry gets the lowest priority next time.
//   req    : in  [N]      request vector
//   ptr    : in  [IDX_W]  index of the last winner
//   grant  : out [N]      one-hot grant (all zero when nothing requests)
//   winner : out [IDX_W]  index of the granted entry (0 when !any)
//   any    : out          at least one request present
module rr_picker #(
    parameter int N     = 7,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    always_comb begin
        int idx;
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(ptr) + k;
            // ptr is always below N, so one subtraction completes the wrap
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                winner     = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter. Each functional unit owns one hold slot; a
// finished result is captured into its slot and later broadcast on the
// registered CDB with tag = unit index + 1. One slot is broadcast per
// cycle, chosen round-robin, so every held result leaves within
// NUM_UNITS cycles.
//   CLOCK_50    : in                 clock
//   RSTN_N      : in                 asynchronous active-low reset
//   req_valid   : in  [NUM_UNITS]    unit i has a finished result
//   req_data    : in  [NUM_UNITS*DATA_W] unit i result in slice i
//   req_ready   : out [NUM_UNITS]    unit i result accepted this cycle
//   flush       : in                 discard all held results
//   cdb_valid   : out                broadcast strobe (one cycle per result)
//   cdb_tag     : out [TAG_W]        producing unit index + 1
//   cdb_data    : out [DATA_W]       broadcast result
//   pending_cnt : out [TAG_W+1]      number of occupied hold slots
module cdb_arbiter #(
    parameter int NUM_UNITS = cpu_pkg::NUM_UNITS,
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int TAG_W     = cpu_pkg::TAG_W
) (
    input  logic                        CLOCK_50,
    input  logic                        RSTN_N,
    input  logic [NUM_UNITS-1:0]        req_valid,
    input  logic [NUM_UNITS*DATA_W-1:0] req_data,
    output logic [NUM_UNITS-1:0]        req_ready,
    input  logic                        flush,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [TAG_W:0]              pending_cnt
);

    import cpu_pkg::*;

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0] hold_v_q, hold_v_d;
    logic [DATA_W-1:0]    hold_d_q [NUM_UNITS];
    logic [DATA_W-1:0]    hold_d_d [NUM_UNITS];
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    cdb_t                 cdb_q, cdb_d;

    logic [NUM_UNITS-1:0] grant;
    logic [NUM_UNITS-1:0] accept;
    logic [IDX_W-1:0]     winner;
    logic                 any;

    rr_picker #(
        .N     (NUM_UNITS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (hold_v_q),
        .ptr    (rr_ptr_q),
        .grant  (grant),
        .winner (winner),
        .any    (any)
    );

    // A slot being broadcast this cycle can take a new result on the same
    // edge, so a unit streaming back-to-back results never sees a bubble.
    assign req_ready = {NUM_UNITS{~flush}} & (~hold_v_q | grant);
    assign accept    = req_valid & req_ready;

    always_comb begin
        hold_v_d = hold_v_q;
        hold_d_d = hold_d_q;
        rr_ptr_d = rr_ptr_q;
        cdb_d    = '0;
        cdb_d.tag = TAG_NONE;
        if (flush) begin
            // Flush wins over both capture and broadcast; rr_ptr is kept.
            hold_v_d = '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (accept[i]) begin
                    hold_v_d[i] = 1'b1;
                    // Data is only sampled on acceptance, so X on an idle
                    // unit's bus never reaches the slot or the CDB.
                    hold_d_d[i] = req_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    hold_v_d[i] = 1'b0;
                end
            end
            if (any) begin
                cdb_d.valid = 1'b1;
                cdb_d.tag   = TAG_W'(winner) + TAG_W'(1);
                cdb_d.data  = hold_d_q[winner];
                rr_ptr_d    = winner;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            hold_v_q <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                hold_d_q[i] <= '0;
            end
            // Pointer at the last unit makes unit 0 the first candidate.
            rr_ptr_q <= IDX_W'(NUM_UNITS - 1);
            cdb_q    <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            hold_d_q <= hold_d_d;
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            pending_cnt = pending_cnt + (TAG_W+1)'(hold_v_q[i]);
        end
    end

    assign cdb_valid = cdb_q.valid;
    assign cdb_tag   = cdb_q.tag;
    assign cdb_data  = cdb_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. Expected broadcasts are queued when the
// stimulus is driven and compared as the CDB produces them.
module tb_cdb_arbiter;

    localparam int NU = 7;
    localparam int DW = 32;
    localparam int TW = 3;

    logic              CLOCK_50;
    logic              RSTN_N;
    logic [NU-1:0]     req_valid;
    logic [NU*DW-1:0]  req_data;
    logic [NU-1:0]     req_ready;
    logic              flush;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [TW:0]       pending_cnt;

    cdb_arbiter #(.NUM_UNITS(NU), .DATA_W(DW), .TAG_W(TW)) dut (
        .CLOCK_50    (CLOCK_50),
        .RSTN_N      (RSTN_N),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .flush       (flush),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .pending_cnt (pending_cnt)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   count_mode = 1'b0;
    int   last_seen [8];
    int   tag_cnt   [8];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_exp(input int tag, input logic [DW-1:0] data);
        exp_t e;
        e.tag  = TW'(tag);
        e.data = data;
        sb.push_back(e);
        $display("drive: expect tag=%0d data=%0h", tag, data);
    endtask

    // Runs once per clock, 1 time unit after the rising edge.
    task automatic monitor();
        exp_t e;
        cyc++;
        if (count_mode) begin
            chk("cnt_valid", 64'(cdb_valid), 64'd1);
            if (cdb_valid === 1'b1 && cdb_tag >= 1 && cdb_tag <= 7) begin
                int t;
                t = int'(cdb_tag);
                chk("cnt_data", 64'(cdb_data), 64'(1000 + t - 1));
                if (last_seen[t] >= 0) begin
                    chk("cnt_gap_le7", 64'((cyc - last_seen[t]) <= 7), 64'd1);
                end
                last_seen[t] = cyc;
                tag_cnt[t]++;
            end
        end else if (cdb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("cdb_spurious", 64'(cdb_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                $display("cdb: tag=%0d data=%0h (expected tag=%0d data=%0h)",
                         cdb_tag, cdb_data, e.tag, e.data);
                chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
                chk("cdb_data", 64'(cdb_data), 64'(e.data));
            end
        end else begin
            chk("idle_valid", 64'(cdb_valid), 64'd0);
            chk("idle_tag", 64'(cdb_tag), 64'd0);
            chk("idle_data", 64'(cdb_data), 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        monitor();
    endtask

    task automatic set_data(input int u, input logic [DW-1:0] d);
        req_data[u*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_data  = 'x;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        RSTN_N = 1'b0;
        @(negedge CLOCK_50);
        RSTN_N = 1'b1;
        tick();
    endtask

    initial begin
        RSTN_N    = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int t = 0; t < 8; t++) begin
            last_seen[t] = -1;
            tag_cnt[t]   = 0;
        end

        // ---- reset state ----
        #3;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        chk("rst_data", 64'(cdb_data), 64'd0);
        chk("rst_pending", 64'(pending_cnt), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'h7f);
        @(negedge CLOCK_50);
        RSTN_N = 1'b1;
        idle_inputs();
        tick();

        // ---- single result, unit 2 ----
        req_valid[2] = 1'b1;
        set_data(2, 32'h0000_0005);
        #1;
        chk("t1_ready2", 64'(req_ready[2]), 64'd1);
        push_exp(3, 32'h5);
        tick();
        chk("t1_pend_cap", 64'(pending_cnt), 64'd1);
        idle_inputs();
        tick();
        chk("t1_bcast_valid", 64'(cdb_valid), 64'd1);
        chk("t1_pend_after", 64'(pending_cnt), 64'd0);
        tick();
        chk("t1_valid_drop", 64'(cdb_valid), 64'd0);
        chk("t1_drain", 64'(sb.size()), 64'd0);

        // ---- three simultaneous results after fresh reset ----
        do_reset();
        req_valid = 7'b100_1001;
        set_data(0, 32'd11);
        set_data(3, 32'd22);
        set_data(6, 32'd33);
        push_exp(1, 32'd11);
        push_exp(4, 32'd22);
        push_exp(7, 32'd33);
        tick();
        chk("t2_pend3", 64'(pending_cnt), 64'd3);
        idle_inputs();
        tick();
        chk("t2_pend2", 64'(pending_cnt), 64'd2);
        tick();
        chk("t2_pend1", 64'(pending_cnt), 64'd1);
        tick();
        chk("t2_pend0", 64'(pending_cnt), 64'd0);
        tick();
        chk("t2_drain", 64'(sb.size()), 64'd0);

        // ---- all units saturated for 70 cycles ----
        req_valid = '1;
        for (int u = 0; u < NU; u++) set_data(u, 32'(1000 + u));
        tick();
        chk("t3_pend_full", 64'(pending_cnt), 64'd7);
        count_mode = 1'b1;
        repeat (70) tick();
        count_mode = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            $display("tag %0d broadcast %0d times", t, tag_cnt[t]);
            chk("t3_tag_count", 64'(tag_cnt[t]), 64'd10);
        end
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_pend", 64'(pending_cnt), 64'd0);

        // ---- unit 4 refills on its grant edge ----
        req_valid[4] = 1'b1;
        set_data(4, 32'd100);
        tick();
        chk("t4_pend1", 64'(pending_cnt), 64'd1);
        set_data(4, 32'd200);
        #1;
        chk("t4_ready_refill", 64'(req_ready[4]), 64'd1);
        push_exp(5, 32'd100);
        tick();
        chk("t4_pend_refilled", 64'(pending_cnt), 64'd1);
        idle_inputs();
        #1;
        chk("t4_ready_again", 64'(req_ready[4]), 64'd1);
        push_exp(5, 32'd200);
        tick();
        chk("t4_pend0", 64'(pending_cnt), 64'd0);
        tick();
        chk("t4_drain", 64'(sb.size()), 64'd0);

        // ---- flush with three held and a new request ----
        req_valid = 7'b010_0101;
        set_data(0, 32'd50);
        set_data(2, 32'd52);
        set_data(5, 32'd55);
        tick();
        chk("t5_pend3", 64'(pending_cnt), 64'd3);
        idle_inputs();
        flush = 1'b1;
        req_valid[1] = 1'b1;
        set_data(1, 32'd77);
        #1;
        chk("t5_ready_flush", 64'(req_ready), 64'd0);
        tick();
        chk("t5_pend_flushed", 64'(pending_cnt), 64'd0);
        flush = 1'b0;
        #1;
        chk("t5_ready_retry", 64'(req_ready), 64'h7f);
        push_exp(2, 32'd77);
        tick();
        chk("t5_pend_retry", 64'(pending_cnt), 64'd1);
        idle_inputs();
        tick();
        tick();
        chk("t5_drain", 64'(sb.size()), 64'd0);

        // ---- asynchronous reset while broadcasting ----
        req_valid[3] = 1'b1;
        set_data(3, 32'd9);
        push_exp(4, 32'd9);
        tick();
        req_valid[3] = 1'b1;
        set_data(3, 32'd10);
        tick();
        chk("t6_valid_before", 64'(cdb_valid), 64'd1);
        chk("t6_pend_before", 64'(pending_cnt), 64'd1);
        #2;
        RSTN_N = 1'b0;
        #1;
        chk("t6_valid_async", 64'(cdb_valid), 64'd0);
        chk("t6_tag_async", 64'(cdb_tag), 64'd0);
        chk("t6_data_async", 64'(cdb_data), 64'd0);
        chk("t6_pend_async", 64'(pending_cnt), 64'd0);
        chk("t6_ready_async", 64'(req_ready), 64'h7f);
        idle_inputs();
        @(negedge CLOCK_50);
        RSTN_N = 1'b1;
        tick();
        tick();
        chk("t6_drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
